// File: rtl/clock_set_ctrl.sv
`default_nettype none
// ============================================================================
// clock_set_ctrl : front-panel button conditioning and edit-mode controller
//                  for the clock/calendar counter.
// Revision 1.0
// ============================================================================
module clock_set_ctrl #(
    parameter logic [19:0] DEBOUNCE_CYCLES = 20'd999_999,
    parameter logic [24:0] BLINK_HALF      = 25'd12_499_999,
    parameter logic [25:0] REPEAT_DELAY    = 26'd24_999_999,
    parameter logic [22:0] REPEAT_PERIOD   = 23'd4_999_999,
    parameter logic [3:0]  TIMEOUT_S       = 4'd10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_butt_change,
    input  logic       i_butt_increase,
    input  logic       i_butt_decrease,
    input  logic       i_sw_mode,
    input  logic       i_tick_1s,
    output logic       o_edit_active,
    output logic [2:0] o_field_sel,
    output logic       o_inc_pulse,
    output logic       o_dec_pulse,
    output logic [7:0] o_blank_mask
);

    localparam logic [1:0] c_ST_RUN = 2'd0;
    localparam logic [1:0] c_ST_F0  = 2'd1;
    localparam logic [1:0] c_ST_F1  = 2'd2;
    localparam logic [1:0] c_ST_F2  = 2'd3;

    // Button index: 0 change, 1 increase, 2 decrease.
    logic [2:0]  w_raw_n;
    logic [2:0]  w_acc;
    logic [2:0]  w_press;
    logic [1:0]  w_cmd;
    logic        w_both;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic        r_mode_s1, r_mode_s2, r_mode_s3;
    logic        w_mode_chg;
    logic [3:0]  r_sec;
    logic [24:0] r_blink_cnt;
    logic        r_blink_off;
    logic        w_edit, w_edit_nxt, w_timeout, w_cmd_ok, w_inc_go, w_dec_go;
    logic        w_blink_clr, w_blink_wrap, w_blink_off_nxt;
    logic [2:0]  w_field_nxt;
    logic [7:0]  w_mask_nxt;

    assign w_raw_n = {i_butt_decrease, i_butt_increase, i_butt_change};
    assign w_both  = w_acc[1] & w_acc[2];

    for (genvar gi = 0; gi < 3; gi++) begin : g_btn
        logic        r_s1, r_s2, r_lvl, r_evt;
        logic [19:0] r_cnt;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_s1  <= 1'b0;
                r_s2  <= 1'b0;
                r_lvl <= 1'b0;
                r_evt <= 1'b0;
                r_cnt <= '0;
            end else begin
                r_s1  <= ~w_raw_n[gi];
                r_s2  <= r_s1;
                r_evt <= 1'b0;
                if (r_s2 == r_lvl) begin
                    r_cnt <= '0;
                end else if (r_cnt == DEBOUNCE_CYCLES) begin
                    r_cnt <= '0;
                    r_lvl <= r_s2;
                    r_evt <= r_s2;
                end else begin
                    r_cnt <= r_cnt + 20'd1;
                end
            end
        end
        assign w_acc[gi]   = r_lvl;
        assign w_press[gi] = r_evt;
    end

    // Lock keeps a button held across a change press from acting on the new field.
    for (genvar gi = 0; gi < 2; gi++) begin : g_rep
        localparam int c_B = gi + 1;
        logic        r_lock, r_per, r_rep;
        logic [25:0] r_hold;
        logic [25:0] w_limit;
        assign w_limit = r_per ? {3'b000, REPEAT_PERIOD} : REPEAT_DELAY;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_lock <= 1'b0;
                r_per  <= 1'b0;
                r_rep  <= 1'b0;
                r_hold <= '0;
            end else begin
                if (!w_acc[c_B])
                    r_lock <= 1'b0;
                else if (w_press[0])
                    r_lock <= 1'b1;
                if (!w_acc[c_B] || w_both || r_lock || w_press[0]) begin
                    r_hold <= '0;
                    r_per  <= 1'b0;
                    r_rep  <= 1'b0;
                end else if (r_hold + 26'd1 == w_limit) begin
                    r_hold <= '0;
                    r_per  <= 1'b1;
                    r_rep  <= 1'b1;
                end else begin
                    r_hold <= r_hold + 26'd1;
                    r_rep  <= 1'b0;
                end
            end
        end
        assign w_cmd[gi] = (w_press[c_B] | r_rep) & ~w_both & ~r_lock;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode_s1 <= 1'b0;
            r_mode_s2 <= 1'b0;
            r_mode_s3 <= 1'b0;
        end else begin
            r_mode_s1 <= i_sw_mode;
            r_mode_s2 <= r_mode_s1;
            r_mode_s3 <= r_mode_s2;
        end
    end

    assign w_mode_chg = r_mode_s2 ^ r_mode_s3;
    assign w_edit     = (r_state != c_ST_RUN);
    assign w_timeout  = w_edit & i_tick_1s & (r_sec + 4'd1 == TIMEOUT_S);
    assign w_cmd_ok   = w_edit & ~w_mode_chg & ~w_timeout & ~w_press[0];
    assign w_inc_go   = w_cmd_ok & w_cmd[0];
    assign w_dec_go   = w_cmd_ok & w_cmd[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= c_ST_RUN;
            o_edit_active <= 1'b0;
            o_field_sel   <= 3'd0;
            o_inc_pulse   <= 1'b0;
            o_dec_pulse   <= 1'b0;
            o_blank_mask  <= 8'h00;
        end else begin
            r_state       <= w_state_nxt;
            o_edit_active <= w_edit_nxt;
            o_field_sel   <= w_field_nxt;
            o_inc_pulse   <= w_inc_go;
            o_dec_pulse   <= w_dec_go;
            o_blank_mask  <= w_mask_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_edit && w_mode_chg)
            w_state_nxt = c_ST_RUN;
        else if (w_timeout)
            w_state_nxt = c_ST_RUN;
        else if (w_press[0])
            w_state_nxt = (r_state == c_ST_F2) ? c_ST_RUN : r_state + 2'd1;
    end

    assign w_edit_nxt      = (w_state_nxt != c_ST_RUN);
    assign w_blink_clr     = w_edit_nxt & ((w_state_nxt != r_state) | w_inc_go | w_dec_go);
    assign w_blink_wrap    = (r_blink_cnt == BLINK_HALF - 25'd1);
    assign w_blink_off_nxt = w_blink_clr ? 1'b0 : (w_blink_wrap ? ~r_blink_off : r_blink_off);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blink_cnt <= '0;
            r_blink_off <= 1'b0;
            r_sec       <= '0;
        end else begin
            r_blink_off <= w_blink_off_nxt;
            if (w_blink_clr || w_blink_wrap)
                r_blink_cnt <= '0;
            else
                r_blink_cnt <= r_blink_cnt + 25'd1;
            if (!w_edit_nxt || (|w_press))
                r_sec <= '0;
            else if (w_edit && i_tick_1s)
                r_sec <= r_sec + 4'd1;
        end
    end

    always_comb begin
        case (w_state_nxt)
            c_ST_F0: w_field_nxt = r_mode_s2 ? 3'd4 : 3'd1;
            c_ST_F1: w_field_nxt = r_mode_s2 ? 3'd5 : 3'd2;
            c_ST_F2: w_field_nxt = r_mode_s2 ? 3'd6 : 3'd3;
            default: w_field_nxt = 3'd0;
        endcase
        w_mask_nxt = 8'h00;
        if (w_blink_off_nxt) begin
            case (w_field_nxt)
                3'd1, 3'd4: w_mask_nxt = 8'hC0;
                3'd2, 3'd5: w_mask_nxt = 8'h30;
                3'd3:       w_mask_nxt = 8'h0C;
                3'd6:       w_mask_nxt = 8'h0F;
                default:    w_mask_nxt = 8'h00;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_clock_set_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// tb_clock_set_ctrl : randomized self-checking bench; expected event times are
// derived from the button latency, repeat and blink rules.
module tb_clock_set_ctrl;

    localparam int DB       = 4;
    localparam int BH       = 8;
    localparam int RD       = 32;
    localparam int RP       = 8;
    localparam int LAT      = DB + 3;   // raw edge -> output edge
    localparam int MODE_LAT = 2;        // raw sw_mode edge -> RUN edge
    localparam int LOGN     = 8192;

    logic clk = 1'b0, rst_n = 1'b0;
    logic b_chg = 1'b1, b_inc = 1'b1, b_dec = 1'b1, sw = 1'b0, tick = 1'b0;
    logic       ea, incp, decp;
    logic [2:0] fs;
    logic [7:0] bm;

    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;

    logic [2:0] lg_fs  [LOGN];
    logic       lg_ea  [LOGN];
    logic       lg_inc [LOGN];
    logic       lg_dec [LOGN];
    logic [7:0] lg_bm  [LOGN];

    clock_set_ctrl #(
        .DEBOUNCE_CYCLES(20'd4), .BLINK_HALF(25'd8), .REPEAT_DELAY(26'd32),
        .REPEAT_PERIOD(23'd8), .TIMEOUT_S(4'd3)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_butt_change(b_chg), .i_butt_increase(b_inc), .i_butt_decrease(b_dec),
        .i_sw_mode(sw), .i_tick_1s(tick),
        .o_edit_active(ea), .o_field_sel(fs), .o_inc_pulse(incp),
        .o_dec_pulse(decp), .o_blank_mask(bm)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (cyc < LOGN) begin
            lg_fs[cyc]  = fs;
            lg_ea[cyc]  = ea;
            lg_inc[cyc] = incp;
            lg_dec[cyc] = decp;
            lg_bm[cyc]  = bm;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete at cycle %0d", cyc);
        $fatal(1);
    end

    function automatic logic [2:0] exp_field(input logic mode, input int step);
        if (step == 0) return 3'd0;
        return mode ? 3'(3 + step) : 3'(step);
    endfunction

    function automatic logic [7:0] exp_mask(input logic [2:0] f);
        case (f)
            3'd1, 3'd4: return 8'hC0;
            3'd2, 3'd5: return 8'h30;
            3'd3:       return 8'h0C;
            3'd6:       return 8'h0F;
            default:    return 8'h00;
        endcase
    endfunction

    // After return, inputs set now are first sampled at edge cyc+1.
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_chg(output int k);
        b_chg = 1'b0;
        k = cyc + 1;
        idle(int'($urandom_range(14, 8)));
        b_chg = 1'b1;
        idle(12);
    endtask

    task automatic test_reset();
        int s;
        rst_n = 1'b0;
        idle(3);
        n_checks++;
        if ({ea, fs, incp, decp, bm} !== 14'd0) begin
            n_errors++;
            $display("FAIL reset_outputs got=%h exp=0", {ea, fs, incp, decp, bm});
        end
        rst_n = 1'b1;
        s = cyc + 1;
        idle(100);
        for (int e = s; e < cyc; e++) begin
            n_checks++;
            if ({lg_ea[e], lg_fs[e], lg_inc[e], lg_dec[e], lg_bm[e]} !== 14'd0) begin
                n_errors++;
                $display("FAIL idle_outputs e=%0d got=%h exp=0", e,
                         {lg_ea[e], lg_fs[e], lg_inc[e], lg_dec[e], lg_bm[e]});
            end
        end
        b_inc = 1'b0;
        s = cyc + 1;
        idle(LAT + RD + 10);
        b_inc = 1'b1;
        idle(12);
        for (int e = s; e < cyc; e++) begin
            n_checks++;
            if (lg_inc[e] !== 1'b0) begin
                n_errors++;
                $display("FAIL run_inc_suppressed e=%0d got=%b exp=0", e, lg_inc[e]);
            end
        end
    endtask

    task automatic test_change_cycle();
        int k;
        logic [2:0] f_prev, f_exp;
        for (int i = 0; i < 4; i++) begin
            press_chg(k);
            f_prev = exp_field(1'b0, i);
            f_exp  = exp_field(1'b0, (i + 1) % 4);
            n_checks++;
            if (lg_fs[k+LAT-1] !== f_prev) begin
                n_errors++;
                $display("FAIL chg_before step=%0d got=%0d exp=%0d", i, lg_fs[k+LAT-1], f_prev);
            end
            n_checks++;
            if (lg_fs[k+LAT] !== f_exp) begin
                n_errors++;
                $display("FAIL chg_field step=%0d got=%0d exp=%0d", i, lg_fs[k+LAT], f_exp);
            end
            n_checks++;
            if (lg_ea[k+LAT] !== (f_exp != 3'd0)) begin
                n_errors++;
                $display("FAIL chg_edit step=%0d got=%b exp=%b", i, lg_ea[k+LAT], (f_exp != 3'd0));
            end
            n_checks++;
            if (lg_bm[k+LAT+BH] !== exp_mask(f_exp)) begin
                n_errors++;
                $display("FAIL chg_blank step=%0d got=%h exp=%h", i, lg_bm[k+LAT+BH], exp_mask(f_exp));
            end
        end
    endtask

    task automatic test_repeat();
        int k, r, g0, h;
        logic exp_p;
        press_chg(k);
        n_checks++;
        if (lg_fs[k+LAT] !== 3'd1) begin
            n_errors++;
            $display("FAIL rep_enter got=%0d exp=1", lg_fs[k+LAT]);
        end
        b_inc = 1'b0;
        g0 = cyc + 1;
        idle(3);
        b_inc = 1'b1;
        idle(20);
        for (int e = g0; e < cyc; e++) begin
            n_checks++;
            if (lg_inc[e] !== 1'b0) begin
                n_errors++;
                $display("FAIL glitch_inc e=%0d got=%b exp=0", e, lg_inc[e]);
            end
        end
        h = int'($urandom_range(70, 50));
        b_inc = 1'b0;
        k = cyc + 1;
        idle(h);
        b_inc = 1'b1;
        r = cyc + 1;
        idle(20);
        for (int e = k; e < cyc; e++) begin
            exp_p = (e == k + LAT) ||
                    (e >= k + LAT + RD && (e - k - LAT - RD) % RP == 0 && e <= r + LAT);
            n_checks++;
            if (lg_inc[e] !== exp_p || lg_dec[e] !== 1'b0) begin
                n_errors++;
                $display("FAIL repeat_pulse t=%0d got=%b%b exp=%b0", e - k, lg_inc[e], lg_dec[e], exp_p);
            end
        end
    endtask

    task automatic test_change_cancel();
        int k, c, c2;
        b_inc = 1'b0;
        k = cyc + 1;
        idle(10);
        press_chg(c);
        idle(50);
        b_inc = 1'b1;
        idle(15);
        for (int e = k; e < cyc; e++) begin
            n_checks++;
            if (lg_inc[e] !== (e == k + LAT)) begin
                n_errors++;
                $display("FAIL cancel_inc t=%0d got=%b exp=%b", e - k, lg_inc[e], (e == k + LAT));
            end
        end
        n_checks++;
        if (lg_fs[c+LAT] !== 3'd2) begin
            n_errors++;
            $display("FAIL cancel_field got=%0d exp=2", lg_fs[c+LAT]);
        end
        press_chg(c2);
        press_chg(c2);
        n_checks++;
        if (lg_fs[c2+LAT] !== 3'd0 || lg_ea[c2+LAT] !== 1'b0) begin
            n_errors++;
            $display("FAIL cancel_exit got=%0d/%b exp=0/0", lg_fs[c2+LAT], lg_ea[c2+LAT]);
        end
    endtask

    task automatic test_blink();
        int k, ent, dp, base;
        logic [7:0] exp_b;
        sw = 1'b1;
        idle(6);
        for (int i = 1; i <= 3; i++) begin
            press_chg(k);
            n_checks++;
            if (lg_fs[k+LAT] !== exp_field(1'b1, i)) begin
                n_errors++;
                $display("FAIL cal_field step=%0d got=%0d exp=%0d", i, lg_fs[k+LAT], exp_field(1'b1, i));
            end
        end
        ent = k + LAT;
        idle(int'($urandom_range(40, 30)));
        b_dec = 1'b0;
        k = cyc + 1;
        idle(10);
        b_dec = 1'b1;
        idle(40);
        dp = k + LAT;
        for (int e = ent; e < cyc; e++) begin
            base  = (e >= dp) ? dp : ent;
            exp_b = (((e - base) / BH) % 2 == 1) ? exp_mask(3'd6) : 8'h00;
            n_checks++;
            if (lg_bm[e] !== exp_b || lg_dec[e] !== (e == dp)) begin
                n_errors++;
                $display("FAIL blink t=%0d got=%h/%b exp=%h/%b", e - ent, lg_bm[e], lg_dec[e], exp_b, (e == dp));
            end
        end
        press_chg(k);
        n_checks++;
        if (lg_fs[k+LAT] !== 3'd0 || lg_bm[k+LAT+BH] !== 8'h00) begin
            n_errors++;
            $display("FAIL blink_exit got=%0d/%h exp=0/00", lg_fs[k+LAT], lg_bm[k+LAT+BH]);
        end
    endtask

    task automatic test_timeout();
        int k, t, a;
        sw = 1'b0;
        idle(6);
        press_chg(k);
        press_chg(k);
        n_checks++;
        if (lg_fs[k+LAT] !== 3'd2) begin
            n_errors++;
            $display("FAIL to_enter got=%0d exp=2", lg_fs[k+LAT]);
        end
        for (int i = 0; i < 3; i++) begin
            idle(int'($urandom_range(15, 5)));
            tick = 1'b1;
            t = cyc + 1;
            idle(1);
            tick = 1'b0;
            idle(2);
            n_checks++;
            if (lg_fs[t-1] !== 3'd2) begin
                n_errors++;
                $display("FAIL to_before tick=%0d got=%0d exp=2", i, lg_fs[t-1]);
            end
            n_checks++;
            if (lg_fs[t] !== ((i == 2) ? 3'd0 : 3'd2)) begin
                n_errors++;
                $display("FAIL to_after tick=%0d got=%0d exp=%0d", i, lg_fs[t], (i == 2) ? 0 : 2);
            end
        end
        press_chg(k);
        n_checks++;
        if (lg_fs[k+LAT] !== 3'd1) begin
            n_errors++;
            $display("FAIL abort_enter got=%0d exp=1", lg_fs[k+LAT]);
        end
        sw = 1'b1;
        a = cyc + 1;
        idle(6);
        n_checks++;
        if (lg_fs[a+MODE_LAT-1] !== 3'd1) begin
            n_errors++;
            $display("FAIL abort_before got=%0d exp=1", lg_fs[a+MODE_LAT-1]);
        end
        n_checks++;
        if (lg_fs[a+MODE_LAT] !== 3'd0 || lg_ea[a+MODE_LAT] !== 1'b0) begin
            n_errors++;
            $display("FAIL abort_run got=%0d/%b exp=0/0", lg_fs[a+MODE_LAT], lg_ea[a+MODE_LAT]);
        end
    endtask

    task automatic test_both();
        int k, r, r2;
        logic exp_p;
        press_chg(k);
        n_checks++;
        if (lg_fs[k+LAT] !== 3'd4) begin
            n_errors++;
            $display("FAIL both_enter got=%0d exp=4", lg_fs[k+LAT]);
        end
        b_inc = 1'b0;
        b_dec = 1'b0;
        k = cyc + 1;
        idle(int'($urandom_range(70, 50)));
        b_dec = 1'b1;
        r = cyc + 1;
        idle(int'($urandom_range(60, 45)));
        b_inc = 1'b1;
        r2 = cyc + 1;
        idle(20);
        for (int e = k; e < cyc; e++) begin
            exp_p = (e >= r + LAT + RD) && ((e - r - LAT - RD) % RP == 0) && (e <= r2 + LAT);
            n_checks++;
            if (lg_inc[e] !== exp_p || lg_dec[e] !== 1'b0) begin
                n_errors++;
                $display("FAIL both_pulse t=%0d got=%b%b exp=%b0", e - k, lg_inc[e], lg_dec[e], exp_p);
            end
        end
    endtask

    task automatic test_reset_mid_edit();
        int s;
        n_checks++;
        if (ea !== 1'b1 || fs !== 3'd4) begin
            n_errors++;
            $display("FAIL mid_pre got=%b/%0d exp=1/4", ea, fs);
        end
        b_inc = 1'b0;
        idle(LAT - 1);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({ea, fs, incp, decp, bm} !== 14'd0) begin
            n_errors++;
            $display("FAIL mid_reset got=%h exp=0", {ea, fs, incp, decp, bm});
        end
        idle(3);
        b_inc = 1'b1;
        rst_n = 1'b1;
        s = cyc + 1;
        idle(20);
        for (int e = s; e < cyc; e++) begin
            n_checks++;
            if (lg_inc[e] !== 1'b0 || lg_fs[e] !== 3'd0 || lg_ea[e] !== 1'b0) begin
                n_errors++;
                $display("FAIL mid_after e=%0d got=%b/%0d/%b exp=0/0/0", e, lg_inc[e], lg_fs[e], lg_ea[e]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_change_cycle();
        test_repeat();
        test_change_cancel();
        test_blink();
        test_timeout();
        test_both();
        test_reset_mid_edit();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
